// File: rtl/mdu_pkg.sv
// mdu_pkg: shared op encodings, FSM states and default width for the multiply/divide unit
package mdu_pkg;
  localparam int MDU_WIDTH = 32;
  localparam logic [2:0] MDU_MULT  = 3'd0;
  localparam logic [2:0] MDU_MULTU = 3'd1;
  localparam logic [2:0] MDU_DIV   = 3'd2;
  localparam logic [2:0] MDU_DIVU  = 3'd3;
  localparam logic [2:0] MDU_MTHI  = 3'd4;
  localparam logic [2:0] MDU_MTLO  = 3'd5;
  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
endpackage

// File: rtl/mdu_signfix.sv
// mdu_signfix: operand magnitude and conditional two's-complement negate of a result
module mdu_signfix #(
  parameter int W  = 32,
  parameter int RW = 64
) (
  input  logic [W-1:0]  a,
  input  logic          a_sgn,
  output logic [W-1:0]  a_abs,
  input  logic [RW-1:0] r,
  input  logic          r_neg,
  output logic [RW-1:0] r_out
);
  assign a_abs = (a_sgn && a[W-1]) ? -a : a;
  assign r_out = r_neg ? -r : r;
endmodule

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: iterative MULT/MULTU/DIV/DIVU unit owning HI/LO, with MTHI/MTLO and flush
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  state_t state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [2*WIDTH-1:0] acc, acc_nxt, fix_q;
  logic [WIDTH-1:0] b_reg, rs_raw, rs_abs, rt_abs, fix_r;
  logic [WIDTH:0] sum, trial;
  logic is_div, neg_q, neg_r, dz, take;
  assign busy = state != IDLE;
  assign take = state == IDLE && start && !flush;
  // acc holds {partial product, multiplier} or {remainder, dividend/quotient}
  assign sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, acc[0] ? b_reg : {WIDTH{1'b0}}};
  assign trial = acc[2*WIDTH-1:WIDTH-1] - {1'b0, b_reg};
  assign acc_nxt = !is_div ? {sum, acc[WIDTH-1:1]} :
                   trial[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0} :
                   {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
  mdu_signfix #(.W(WIDTH), .RW(2*WIDTH)) u_sf_q (
    .a(rs_val), .a_sgn(!op[0] && !op[2]), .a_abs(rs_abs),
    .r(is_div ? {{WIDTH{1'b0}}, acc[WIDTH-1:0]} : acc), .r_neg(neg_q), .r_out(fix_q)
  );
  mdu_signfix #(.W(WIDTH), .RW(WIDTH)) u_sf_r (
    .a(rt_val), .a_sgn(!op[0] && !op[2]), .a_abs(rt_abs),
    .r(acc[2*WIDTH-1:WIDTH]), .r_neg(neg_r), .r_out(fix_r)
  );
  always_comb begin
    state_nxt = flush ? IDLE :
                state == IDLE ? ((start && op <= MDU_DIVU) ? RUN : IDLE) :
                state == RUN ? ((cnt == CNT_W'(WIDTH-1)) ? FIX : RUN) : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      acc    <= '0;
      b_reg  <= '0;
      rs_raw <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      dz     <= 1'b0;
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      state <= state_nxt;
      done  <= state == FIX && !flush;
      if (take && op == MDU_MTHI) hi <= rs_val;
      if (take && op == MDU_MTLO) lo <= rs_val;
      if (take && op <= MDU_DIVU) begin
        cnt    <= '0;
        is_div <= op[1];
        neg_q  <= !op[0] && (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
        neg_r  <= op == MDU_DIV && rs_val[WIDTH-1];
        dz     <= op[1] && rt_val == '0;
        rs_raw <= rs_val;
        b_reg  <= op[1] ? rt_abs : rs_abs;
        acc    <= {{WIDTH{1'b0}}, op[1] ? rs_abs : rt_abs};
      end
      if (state == RUN) begin
        acc <= acc_nxt;
        cnt <= cnt + 1'b1;
      end
      // divide-by-zero reports the dividend exactly as presented, unsigned or not
      if (state == FIX && !flush) begin
        hi <= dz ? rs_raw : is_div ? fix_r : fix_q[2*WIDTH-1:WIDTH];
        lo <= dz ? {WIDTH{1'b1}} : fix_q[WIDTH-1:0];
      end
    end
  end
endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: directed stimulus with a done-driven scoreboard and queued state checks
module tb_mdu_ctrl;
  logic clk, rst_n, start, flush, busy, done;
  logic [2:0] op;
  logic [31:0] rs_val, rt_val, hi, lo;
  typedef struct {
    string name;
    bit kind;
    logic [65:0] exp;
    logic [65:0] act;
  } req_t;
  logic [63:0] sb[$];
  req_t pend[$];
  int checks = 0;
  int errors = 0;
  mdu_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .rs_val(rs_val),
    .rt_val(rt_val), .flush(flush), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(negedge clk) begin
    logic [63:0] e;
    req_t r;
    checks++;
    if (done && busy) begin
      errors++;
      $display("FAIL done_with_busy act=11 exp=not both");
    end
    if (done) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done hi=%h lo=%h", hi, lo);
      end else begin
        e = sb.pop_front();
        if ({hi, lo} !== e) begin
          errors++;
          $display("FAIL result act=%h_%h exp=%h_%h", hi, lo, e[63:32], e[31:0]);
        end
      end
    end
    while (pend.size() > 0) begin
      r = pend.pop_front();
      if (!r.kind) r.act = {busy, done, hi, lo};
      checks++;
      if (r.act !== r.exp) begin
        errors++;
        $display("FAIL %s act=%h exp=%h", r.name, r.act, r.exp);
      end
    end
  end
  task automatic want_out(input string name, input logic b, input logic d, input logic [31:0] h, input logic [31:0] l);
    pend.push_back('{name, 1'b0, {b, d, h, l}, 66'd0});
  endtask
  task automatic want_val(input string name, input int act, input int exp);
    pend.push_back('{name, 1'b1, 66'(exp), 66'(act)});
  endtask
  task automatic pulse(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input logic f);
    start = 1'b1; op = o; rs_val = a; rt_val = b; flush = f;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
  endtask
  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask
  task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el);
    int n;
    sb.push_back({eh, el});
    pulse(o, a, b, 1'b0);
    n = 0;
    while (busy && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    want_val({name, "_busy_cycles"}, n, 33);
  endtask
  initial begin
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = 3'd0; rs_val = '0; rt_val = '0;
    want_out("reset_state", 1'b0, 1'b0, 32'h0, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_op("mult_neg3x7", 3'd0, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB);
    run_op("multu_max", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    run_op("div_neg7by2", 3'd2, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("div_min_by_m1", 3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000);
    run_op("div_7by_neg2", 3'd2, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD);
    run_op("divu_by_zero", 3'd3, 32'd100, 32'd0, 32'd100, 32'hFFFFFFFF);
    run_op("div_neg_by_zero", 3'd2, 32'hFFFFFFF0, 32'd0, 32'hFFFFFFF0, 32'hFFFFFFFF);
    run_op("divu_big", 3'd3, 32'hFFFFFFFF, 32'd10, 32'd5, 32'h19999999);
    cycles(2);
    want_out("done_single_pulse", 1'b0, 1'b0, 32'd5, 32'h19999999);
    pulse(3'd4, 32'h1234, 32'd0, 1'b0);
    want_out("mthi", 1'b0, 1'b0, 32'h1234, 32'h19999999);
    pulse(3'd5, 32'h5678, 32'd0, 1'b0);
    want_out("mtlo", 1'b0, 1'b0, 32'h1234, 32'h5678);
    pulse(3'd0, 32'd5, 32'd6, 1'b0);
    want_out("mult_started", 1'b1, 1'b0, 32'h1234, 32'h5678);
    cycles(3);
    pulse(3'd4, 32'hBAD, 32'd0, 1'b0);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    want_out("flush_run", 1'b0, 1'b0, 32'h1234, 32'h5678);
    cycles(40);
    want_out("flush_no_result", 1'b0, 1'b0, 32'h1234, 32'h5678);
    pulse(3'd4, 32'hDEAD, 32'd0, 1'b1);
    want_out("flush_with_mthi", 1'b0, 1'b0, 32'h1234, 32'h5678);
    pulse(3'd1, 32'd3, 32'd5, 1'b1);
    want_out("flush_with_start", 1'b0, 1'b0, 32'h1234, 32'h5678);
    cycles(40);
    pulse(3'd2, 32'd100, 32'd7, 1'b0);
    cycles(9);
    rst_n = 1'b0;
    want_out("reset_mid_run", 1'b0, 1'b0, 32'h0, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    cycles(2);
    run_op("multu_after_reset", 3'd1, 32'd3, 32'd5, 32'd0, 32'd15);
    cycles(2);
    want_val("scoreboard_drained", sb.size(), 0);
    @(negedge clk); #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
- Iterative multiply/divide unit with controller for the pipelined CPU: MULT/MULTU/DIV/DIVU plus MTHI/MTLO.
- Owns the HI/LO registers.
- Sits beside the EX-stage ALU; accepts an op from EX, runs 32 shift-add or restoring-subtract iterations, and reports busy to the hazard unit so MFHI/MFLO stall.

Parameters:
- WIDTH, 32, operand/HI/LO width.
- CNT_W, 5, iteration counter width (log2 WIDTH).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  op valid from EX (one-cycle pulse per instruction)
- op  in  3  0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO, others no-op
- rs_val  in  WIDTH  operand A (multiplicand/dividend/MT source)
- rt_val  in  WIDTH  operand B (multiplier/divisor)
- flush  in  1  abort in-flight op (exception/branch squash)
- busy  out  1  registered; high while an op is in flight
- done  out  1  registered one-cycle pulse when HI/LO are updated by an iterative op
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
- Reset (async, rst_n=0): state=IDLE, busy=0, done=0, hi=0, lo=0, counter=0, internal operands=0. Applies immediately and also mid-operation; the op is lost.
- States: IDLE, RUN, FIX.
- IDLE, start=1, op 0-3, flush=0: latch |rs|, |rt| (raw values for unsigned ops), result signs, rt==0 flag; counter=0; ->RUN; busy=1 from this edge.
- IDLE, start=1, op 4/5: hi<=rs_val or lo<=rs_val at that edge; stay IDLE; no busy, no done.
- IDLE, op 6/7: ignored.
- RUN: one iteration per cycle.
  - Multiply: shift-add over a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract; remainder in the upper half, quotient in the lower half.
  - Counter increments; at counter==WIDTH-1 ->FIX.
- FIX: apply sign correction, write hi/lo, done=1 for this one edge, busy=0, ->IDLE.
- Latency: start sampled at edge T0; RUN iterations at edges T1..T32; hi/lo and done valid after edge T33. busy is high between edges T0 and T33 (33 cycles).
- Signed multiply: product negated when sign(rs)^sign(rt); {hi,lo} = full 64-bit product.
- Signed divide:
  - Quotient truncates toward zero; lo=quotient, hi=remainder.
  - Remainder takes the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0 (no trap).
- Divide by zero (signed or unsigned): full latency still taken; lo=0xFFFFFFFF, hi=rs_val as originally presented.
- start while busy: ignored; the hazard unit guarantees it never occurs. Not an error.
- MTHI/MTLO while busy: ignored.
- flush=1:
  - In RUN/FIX: ->IDLE at next edge, busy=0, done=0, hi/lo unchanged.
  - Same cycle as start: flush wins, nothing latched, including MT ops.
- done and busy are never both high after the same edge.

Decomposition:
- Shared package mdu_pkg:
  - op encoding constants MDU_MULT..MDU_MTLO
  - state enum IDLE/RUN/FIX
  - WIDTH default
- One natural sub-module, mdu_signfix (combinational): abs-of-operand and conditional two's-complement negate of a 2*WIDTH result. Used at latch and at FIX.
- Iteration datapath and FSM stay in mdu_ctrl.

Test Plan:
- Reset mid-RUN: assert rst_n=0 at cycle 10 of a DIV -> busy=0, done=0, hi=lo=0 immediately; the next MULTU 3x5 completes normally with lo=15, hi=0.
- MULT rs=0xFFFFFFFD (-3), rt=7 -> done after edge T33; hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high exactly 33 cycles.
- MULTU rs=0xFFFFFFFF, rt=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- DIV rs=-7 (0xFFFFFFF9), rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU rs=100, rt=0 -> after 33 cycles lo=0xFFFFFFFF, hi=100, done pulse once.
- MTHI 0x1234 then MTLO 0x5678 in IDLE -> hi/lo update next edge, busy stays 0. Flush at RUN cycle 5 of MULT -> busy=0 next edge, hi/lo keep 0x1234/0x5678, no done. start+flush same cycle -> nothing latched.
